hamming_tx: RTL and testbench
=============================

// Module: hamming_tx
// PURPOSE
//  Transmit end of the 12-bit Hamming(12,8) link: accepts a byte over a valid/ready handshake,
//  encodes it into a 12-bit single-error-correcting codeword, and serialises it as a framed
//  stream (start, 12 code bits LSB first, stop). The codeword layout matches the link receiver,
//  so the received word decodes with a zero syndrome. An optional single-bit error-injection
//  input exercises the receiver's correction path.
// PARAMETERS
//  CLKS_PER_BIT  4  clk cycles per serial bit; legal 1..255
//  STOP_BITS     1  stop bits per frame; legal 1 or 2
// PORTS
//  clk          in   1   single clock; all state changes on the rising edge
//  rst          in   1   asynchronous, active-high reset
//  in_data      in   8   byte to send; sampled on handshake
//  in_valid     in   1   in_data/inj_pos valid
//  in_ready     out  1   block can accept; = (state==IDLE)
//  inj_pos      in   4   0: no error; 1..12: invert codeword bit (inj_pos-1); 13..15: treated as 0
//  tx           out  1   serial line; idle high
//  code_out     out  12  last transmitted codeword (after injection)
//  busy         out  1   high in START/DATA/STOP
//  frame_done   out  1   one-cycle pulse in the final clk cycle of the last stop bit
// BEHAVIOUR
//  Reset values: tx=1, busy=0, frame_done=0, code_out=12'h000, state=IDLE (so in_ready=1).
//  Encoding (d=in_data, c=codeword): c2=d0 c4=d1 c5=d2 c6=d3 c8=d4 c9=d5 c10=d6 c11=d7;
//   c0=d0^d1^d3^d4^d6; c1=d0^d2^d3^d5^d6; c3=d1^d2^d3^d7; c7=d4^d5^d6^d7.
//   Injection: if inj_pos in 1..12, c[inj_pos-1] is inverted before storage.
//  Handshake: transfer when in_valid & in_ready at a rising edge. On that edge the shift
//   register and code_out load the (possibly corrupted) codeword; state -> START.
//   in_valid while not ready is ignored; in_data/inj_pos need not be held after transfer.
//  FSM (bit counter bcnt 0..11, tick counter 0..CLKS_PER_BIT-1):
//   IDLE : tx=1. Handshake -> START.
//   START: tx=0 for CLKS_PER_BIT cycles -> DATA, bcnt=0.
//   DATA : tx=c[bcnt] for CLKS_PER_BIT cycles each; after bcnt=11 -> STOP.
//   STOP : tx=1 for STOP_BITS*CLKS_PER_BIT cycles; frame_done in final cycle; -> IDLE.
//  tx is driven from a register (glitch-free). Frame length from the cycle after acceptance:
//   (13+STOP_BITS)*CLKS_PER_BIT cycles. Back-to-back: next byte accepted on the first IDLE
//   cycle, i.e. at least one idle-high cycle between frames.
//  code_out changes only on handshake; holds between frames.
//  CLKS_PER_BIT=1: every state lasts exactly one cycle per bit; counters never wrap incorrectly.
//  Reset mid-frame: tx returns high and busy low immediately (async); frame abandoned,
//   no frame_done; first post-reset handshake starts a clean frame.
//  in_valid asserted in the same cycle frame_done pulses: not accepted (ready still low);
//   accepted on the following cycle.
// TESTING
//  1 rst pulse mid-DATA -> tx=1, busy=0, in_ready=1 same cycle as rst; no frame_done.
//  2 in_data=8'h00, inj_pos=0 -> code_out=12'h000; tx: 0, twelve 0s, 1 (each 4 clks).
//  3 in_data=8'hFF, inj_pos=0 -> code_out=12'hF77; serial bits LSB first 1,1,1,0,1,1,1,0,1,1,1,1.
//  4 in_data=8'hA5, inj_pos=0 -> code_out=12'hA27; receiver outputs 8'hA5; frame_done after 56 clks.
//  5 in_data=8'hA5, inj_pos=5 -> code_out=12'hA37; receiver still outputs 8'hA5; inj_pos=14 -> 12'hA27.
//  6 in_valid held high, bytes 01,02,03, STOP_BITS=2, CLKS_PER_BIT=1 -> frames 15 clks long,
//    one idle-high cycle between, all three received in order; random 1000-byte sweep with
//    random inj_pos decodes error-free.

Source files
------------

// File: rtl/hamming_tx.sv
// Hamming(12,8) transmitter: encodes an accepted byte (with optional single-bit error injection)
// and serialises start, 12 code bits LSB first, then stop bit(s), with tx driven from a flop.
module hamming_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  inj_pos,
  output logic        tx,
  output logic [11:0] code_out,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [8:0] BIT_LAST  = 9'(CLKS_PER_BIT - 1);
  localparam logic [8:0] STOP_LAST = 9'(STOP_BITS * CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [8:0]  tick_q, tick_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic [11:0] code_q, code_d;
  logic        tx_q, tx_d;
  logic [3:0]  bcnt_nxt;

  function automatic logic [11:0] encode(input logic [7:0] d, input logic [3:0] pos);
    logic [11:0] c;
    logic [3:0]  idx;
    c[2]  = d[0];
    c[4]  = d[1];
    c[5]  = d[2];
    c[6]  = d[3];
    c[8]  = d[4];
    c[9]  = d[5];
    c[10] = d[6];
    c[11] = d[7];
    c[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    c[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    c[3]  = d[1] ^ d[2] ^ d[3] ^ d[7];
    c[7]  = d[4] ^ d[5] ^ d[6] ^ d[7];
    // Positions 13..15 fall outside the codeword and leave it untouched
    idx = pos - 4'd1;
    if (pos != 4'd0 && pos <= 4'd12) c[idx] = ~c[idx];
    return c;
  endfunction

  assign bcnt_nxt = bcnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bcnt_d  = bcnt_q;
    code_d  = code_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (in_valid) begin
          code_d  = encode(in_data, inj_pos);
          state_d = START;
          tick_d  = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tick_q == BIT_LAST) begin
          state_d = DATA;
          tick_d  = '0;
          bcnt_d  = '0;
          tx_d    = code_q[0];
        end else begin
          tick_d = tick_q + 9'd1;
        end
      end
      DATA: begin
        if (tick_q == BIT_LAST) begin
          tick_d = '0;
          if (bcnt_q == 4'd11) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bcnt_d = bcnt_nxt;
            tx_d   = code_q[bcnt_nxt];
          end
        end else begin
          tick_d = tick_q + 9'd1;
        end
      end
      STOP: begin
        if (tick_q == STOP_LAST) begin
          state_d = IDLE;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + 9'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bcnt_q  <= '0;
      code_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bcnt_q  <= bcnt_d;
      code_q  <= code_d;
      tx_q    <= tx_d;
    end
  end

  // Status outputs decode flops only, so reset reaches them without a clock edge
  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == STOP) && (tick_q == STOP_LAST);
  assign tx         = tx_q;
  assign code_out   = code_q;

endmodule

// File: tb/tb_hamming_tx.sv
// Directed and swept checks of hamming_tx at two parameter points (4 clk/bit 1 stop, 1 clk/bit 2 stop).
module tb_hamming_tx;

  logic        clk = 1'b0;
  logic        rst;

  logic [7:0]  a_data, b_data;
  logic        a_vld, b_vld, a_rdy, b_rdy;
  logic [3:0]  a_inj, b_inj;
  logic        a_tx, b_tx, a_busy, b_busy, a_fd, b_fd;
  logic [11:0] a_code, b_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hamming_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_vld), .in_ready(a_rdy),
    .inj_pos(a_inj), .tx(a_tx), .code_out(a_code), .busy(a_busy), .frame_done(a_fd)
  );

  hamming_tx #(.CLKS_PER_BIT(1), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_vld), .in_ready(b_rdy),
    .inj_pos(b_inj), .tx(b_tx), .code_out(b_code), .busy(b_busy), .frame_done(b_fd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] tb_encode(input logic [7:0] d, input logic [3:0] p);
    logic [11:0] c;
    c = {d[7], d[6], d[5], d[4], d[4]^d[5]^d[6]^d[7], d[3], d[2], d[1],
         d[1]^d[2]^d[3]^d[7], d[0], d[0]^d[2]^d[3]^d[5]^d[6], d[0]^d[1]^d[3]^d[4]^d[6]};
    if (p >= 4'd1 && p <= 4'd12) c = c ^ (12'h001 << (p - 4'd1));
    return c;
  endfunction

  // Receiver: syndrome is the XOR of the 1-based positions of all set bits
  function automatic logic [7:0] rx_decode(input logic [11:0] w);
    logic [11:0] x;
    logic [3:0]  s;
    x = w;
    s = 4'd0;
    for (int i = 0; i < 12; i++) if (x[i]) s = s ^ 4'(i + 1);
    if (s != 4'd0 && s <= 4'd12) x[s - 4'd1] = ~x[s - 4'd1];
    return {x[11], x[10], x[9], x[8], x[6], x[5], x[4], x[2]};
  endfunction

  task automatic send_a(input logic [7:0] d, input logic [3:0] p, input logic [11:0] exp_code);
    logic [11:0] rxw;
    logic        exp_bit;
    int          n;
    n = 0;
    @(negedge clk);
    while (!a_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("a_rdy_wait", 32'(n < 200), 32'd1);
    a_data = d;
    a_inj  = p;
    a_vld  = 1'b1;
    @(posedge clk);
    #1;
    a_vld  = 1'b0;
    a_data = ~d;
    a_inj  = 4'd0;
    rxw    = '0;
    for (int cyc = 0; cyc < 56; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("a_code_out", 32'(a_code), 32'(exp_code));
      if (cyc < 4)       exp_bit = 1'b0;
      else if (cyc < 52) exp_bit = exp_code[(cyc - 4) / 4];
      else               exp_bit = 1'b1;
      chk("a_tx", 32'(a_tx), 32'(exp_bit));
      chk("a_busy", 32'(a_busy), 32'd1);
      chk("a_frame_done", 32'(a_fd), 32'(cyc == 55));
      if (cyc >= 4 && cyc < 52 && (cyc % 4) == 2) rxw[(cyc - 4) / 4] = a_tx;
    end
    chk("a_rx_byte", 32'(rx_decode(rxw)), 32'(d));
    @(negedge clk);
    chk("a_idle_busy", 32'(a_busy), 32'd0);
    chk("a_idle_rdy", 32'(a_rdy), 32'd1);
    chk("a_idle_tx", 32'(a_tx), 32'd1);
  endtask

  // in_valid stays high when keep is set, so the next frame must start after exactly one idle cycle
  task automatic send_b(input logic [7:0] d, input logic [3:0] p, input logic keep,
                        input logic [11:0] exp_code);
    logic [11:0] rxw;
    logic        exp_bit;
    int          n;
    n = 0;
    @(negedge clk);
    while (!b_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b_gap", n, 0);
    chk("b_idle_tx", 32'(b_tx), 32'd1);
    b_data = d;
    b_inj  = p;
    b_vld  = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) b_vld = 1'b0;
    b_data = ~d;
    b_inj  = 4'd3;
    rxw    = '0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("b_code_out", 32'(b_code), 32'(exp_code));
      if (cyc == 0)       exp_bit = 1'b0;
      else if (cyc <= 12) exp_bit = exp_code[cyc - 1];
      else                exp_bit = 1'b1;
      chk("b_tx", 32'(b_tx), 32'(exp_bit));
      chk("b_frame_done", 32'(b_fd), 32'(cyc == 14));
      if (cyc >= 1 && cyc <= 12) rxw[cyc - 1] = b_tx;
    end
    chk("b_rx_byte", 32'(rx_decode(rxw)), 32'(d));
  endtask

  initial begin
    int fd_seen;
    logic [7:0] rd;
    logic [3:0] rp;
    rst = 1'b1;
    a_data = '0; a_vld = 1'b0; a_inj = '0;
    b_data = '0; b_vld = 1'b0; b_inj = '0;
    #2;
    chk("rst_tx", 32'(a_tx), 32'd1);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_frame_done", 32'(a_fd), 32'd0);
    chk("rst_code_out", 32'(a_code), 32'h000);
    chk("rst_rdy", 32'(a_rdy), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Abandon a frame part-way through the data bits
    @(negedge clk);
    a_data = 8'hFF; a_inj = 4'd0; a_vld = 1'b1;
    @(posedge clk);
    #1;
    a_vld = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", 32'(a_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tx", 32'(a_tx), 32'd1);
    chk("arst_busy", 32'(a_busy), 32'd0);
    chk("arst_rdy", 32'(a_rdy), 32'd1);
    chk("arst_frame_done", 32'(a_fd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fd_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (a_fd) fd_seen++;
    end
    chk("no_fd_after_rst", fd_seen, 0);

    send_a(8'h00, 4'd0,  12'h000);
    send_a(8'hFF, 4'd0,  12'hF77);
    send_a(8'hA5, 4'd0,  12'hA27);
    send_a(8'hA5, 4'd5,  12'hA37);
    send_a(8'hA5, 4'd14, 12'hA27);
    repeat (5) @(negedge clk);
    chk("code_out_hold", 32'(a_code), 32'hA27);

    send_b(8'h01, 4'd0, 1'b1, 12'h007);
    send_b(8'h02, 4'd0, 1'b1, 12'h019);
    send_b(8'h03, 4'd0, 1'b1, 12'h01E);
    for (int i = 0; i < 1000; i++) begin
      rd = 8'($urandom_range(0, 255));
      rp = 4'($urandom_range(0, 15));
      send_b(rd, rp, 1'b1, tb_encode(rd, rp));
    end
    b_vld = 1'b0;
    @(negedge clk);
    chk("b_end_rdy", 32'(b_rdy), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
